video_top: RTL and testbench

- FPGA top level of the video controller.
- Generates VGA/LCD raster timing and a test pattern from the single 50 MHz board clock.
- Drives board LEDs for status: a key pass-through, a heartbeat and a frame indicator, plus a switch mirror.
- Sits directly under the board pin wrapper; the video outputs go to the DAC/LCD interface.

---
 rtl/video_pkg.sv | 32 +++
 rtl/video_if.sv | 14 +
 rtl/video_vga_timing.sv | 81 ++++++++
 rtl/video_top.sv | 128 ++++++++++++
 tb/tb_video_top.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types, default raster timing and colour constants for the video controller.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned HDISP_DEF  = 800;
  localparam int unsigned VDISP_DEF  = 480;
  localparam int unsigned HFP_DEF    = 40;
  localparam int unsigned HPULSE_DEF = 48;
  localparam int unsigned HBP_DEF    = 40;
  localparam int unsigned VFP_DEF    = 13;
  localparam int unsigned VPULSE_DEF = 3;
  localparam int unsigned VBP_DEF    = 29;

  localparam rgb_t WHITE = rgb_t'(24'hFFFFFF);
  localparam rgb_t BLACK = rgb_t'(24'h000000);

  function automatic int unsigned htotal(input int unsigned disp, input int unsigned fp,
                                         input int unsigned pulse, input int unsigned bp);
    return disp + fp + pulse + bp;
  endfunction

  function automatic int unsigned vtotal(input int unsigned disp, input int unsigned fp,
                                         input int unsigned pulse, input int unsigned bp);
    return disp + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/video_if.sv
// DAC/LCD video output bundle; video_top drives it through the master modport.
interface video_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK;
  logic       VGA_SYNC;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B);
  modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/video_vga_timing.sv
// Raster timing: half-rate pixel enable, x/y counters and registered HS/VS/BLANK decode.
module vga_timing
  import video_pkg::*;
#(
  parameter int unsigned HDISP  = HDISP_DEF,
  parameter int unsigned VDISP  = VDISP_DEF,
  parameter int unsigned HFP    = HFP_DEF,
  parameter int unsigned HPULSE = HPULSE_DEF,
  parameter int unsigned HBP    = HBP_DEF,
  parameter int unsigned VFP    = VFP_DEF,
  parameter int unsigned VPULSE = VPULSE_DEF,
  parameter int unsigned VBP    = VBP_DEF,
  localparam int unsigned HTOTAL = htotal(HDISP, HFP, HPULSE, HBP),
  localparam int unsigned VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP),
  localparam int unsigned XW     = $clog2(HTOTAL),
  localparam int unsigned YW     = $clog2(VTOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_pix_en,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_active,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_blank
);

  localparam logic [XW-1:0] X_LAST = XW'(HTOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(HDISP);
  localparam logic [XW-1:0] HS_BEG = XW'(HDISP + HFP);
  localparam logic [XW-1:0] HS_END = XW'(HDISP + HFP + HPULSE);
  localparam logic [YW-1:0] Y_LAST = YW'(VTOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(VDISP);
  localparam logic [YW-1:0] VS_BEG = YW'(VDISP + VFP);
  localparam logic [YW-1:0] VS_END = YW'(VDISP + VFP + VPULSE);

  logic          r_pix_phase;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic          w_active;

  assign w_active = (r_x < X_ACT) && (r_y < Y_ACT);

  // Decode samples the pre-increment counters, so sync/blank lag x/y by one pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_phase <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_blank     <= 1'b0;
    end else begin
      r_pix_phase <= ~r_pix_phase;
      if (r_pix_phase) begin
        r_hs    <= !((r_x >= HS_BEG) && (r_x < HS_END));
        r_vs    <= !((r_y >= VS_BEG) && (r_y < VS_END));
        r_blank <= w_active;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign o_pix_en = r_pix_phase;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_active = w_active;
  assign o_hs     = r_hs;
  assign o_vs     = r_vs;
  assign o_blank  = r_blank;

endmodule

// File: rtl/video_top.sv
// Video controller top: raster timing, test pattern and status LEDs.
// Define COLOR_BARS_EN for 8 vertical colour bars instead of the 16-pixel grid.
module video_top
  import video_pkg::*;
#(
  parameter int unsigned HDISP  = HDISP_DEF,
  parameter int unsigned VDISP  = VDISP_DEF,
  parameter int unsigned HFP    = HFP_DEF,
  parameter int unsigned HPULSE = HPULSE_DEF,
  parameter int unsigned HBP    = HBP_DEF,
  parameter int unsigned VFP    = VFP_DEF,
  parameter int unsigned VPULSE = VPULSE_DEF,
  parameter int unsigned VBP    = VBP_DEF,
  parameter int unsigned HB_MAX = 25000000
) (
  input  logic       FPGA_CLK1_50,
  input  logic       sys_rst,
  input  logic [1:0] KEY,
  input  logic [3:0] SW,
  output logic [7:0] LED,
  video_if.master    vga
);

  localparam int unsigned HTOTAL = htotal(HDISP, HFP, HPULSE, HBP);
  localparam int unsigned VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP);
  localparam int unsigned XW     = $clog2(HTOTAL);
  localparam int unsigned YW     = $clog2(VTOTAL);
  localparam int unsigned HBW    = (HB_MAX > 1) ? $clog2(HB_MAX) : 1;
  localparam logic [XW-1:0]  X_LAST  = XW'(HTOTAL - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(VTOTAL - 1);
  localparam logic [HBW-1:0] HB_LAST = HBW'(HB_MAX - 1);

  logic          w_pix_en;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic          w_blank;
  rgb_t          w_rgb;
  logic          w_unused_key;

  rgb_t           r_rgb;
  logic [HBW-1:0] r_hb_cnt;
  logic           r_led_hb;
  logic           r_led_frame;
  logic [3:0]     r_sw;

  vga_timing #(
    .HDISP  (HDISP),
    .VDISP  (VDISP),
    .HFP    (HFP),
    .HPULSE (HPULSE),
    .HBP    (HBP),
    .VFP    (VFP),
    .VPULSE (VPULSE),
    .VBP    (VBP)
  ) u_timing (
    .i_clk    (FPGA_CLK1_50),
    .i_rst    (sys_rst),
    .o_pix_en (w_pix_en),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_active (w_active),
    .o_hs     (w_hs),
    .o_vs     (w_vs),
    .o_blank  (w_blank)
  );

`ifdef COLOR_BARS_EN
  logic [2:0] w_bar;
  assign w_bar = 3'((32'(w_x) * 32'd8) / HDISP);

  // Bar order white..black falls out of the inverted index bits: G=~b2, R=~b1, B=~b0.
  always_comb begin
    w_rgb = BLACK;
    if (w_active) begin
      w_rgb.r = {8{~w_bar[1]}};
      w_rgb.g = {8{~w_bar[2]}};
      w_rgb.b = {8{~w_bar[0]}};
    end
  end
`else
  always_comb begin
    w_rgb = BLACK;
    if (w_active && ((w_x[3:0] == 4'd0) || (w_y[3:0] == 4'd0)))
      w_rgb = WHITE;
  end
`endif

  always_ff @(posedge FPGA_CLK1_50) begin
    if (sys_rst) begin
      r_rgb       <= BLACK;
      r_hb_cnt    <= '0;
      r_led_hb    <= 1'b0;
      r_led_frame <= 1'b0;
      r_sw        <= '0;
    end else begin
      r_sw <= SW;
      if (r_hb_cnt == HB_LAST) begin
        r_hb_cnt <= '0;
        r_led_hb <= ~r_led_hb;
      end else begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
      if (w_pix_en) begin
        r_rgb <= w_rgb;
        if ((w_x == X_LAST) && (w_y == Y_LAST))
          r_led_frame <= ~r_led_frame;
      end
    end
  end

  // KEY[1] has no function yet.
  assign w_unused_key = KEY[1];

  assign LED = {r_sw, 1'b0, r_led_frame, r_led_hb, KEY[0]};

  assign vga.VGA_CLK   = ~w_pix_en;
  assign vga.VGA_HS    = w_hs;
  assign vga.VGA_VS    = w_vs;
  assign vga.VGA_BLANK = w_blank;
  assign vga.VGA_SYNC  = 1'b0;
  assign vga.VGA_R     = r_rgb.r;
  assign vga.VGA_G     = r_rgb.g;
  assign vga.VGA_B     = r_rgb.b;

endmodule

// File: tb/tb_video_top.sv
// Directed bench for video_top on a reduced 160x90 raster with an 8-cycle heartbeat.
module tb_video_top;

  localparam int HT = 288;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [3:0] sw;
  logic [7:0] led;
  logic [23:0] rgb;

  int n_checks = 0;
  int n_fails  = 0;
  int edge_n   = 0;

  always #10 clk = ~clk;

  video_if vif ();

  video_top #(
    .HDISP  (160),
    .VDISP  (90),
    .HB_MAX (8)
  ) dut (
    .FPGA_CLK1_50 (clk),
    .sys_rst      (rst),
    .KEY          (key),
    .SW           (sw),
    .LED          (led),
    .vga          (vif)
  );

  assign rgb = {vif.VGA_R, vif.VGA_G, vif.VGA_B};

  typedef struct {
    int          x;
    int          y;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] grid;
    logic [23:0] bars;
    logic        led2;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hs"},    vif.VGA_HS, 1'b1);
    chk({tag, "_vs"},    vif.VGA_VS, 1'b1);
    chk({tag, "_blank"}, vif.VGA_BLANK, 1'b0);
    chk({tag, "_rgb"},   rgb, 24'h000000);
    chk({tag, "_vclk"},  vif.VGA_CLK, 1'b1);
    chk({tag, "_sync"},  vif.VGA_SYNC, 1'b0);
    chk({tag, "_led71"}, led[7:1], 7'h00);
    chk({tag, "_led0"},  led[0], key[0]);
  endtask

  // KEY[0] pass-through while reset is held
  initial begin
    key = 2'b11;
    #5;
    chk("led0_init", led[0], 1'b1);
    #123;
    key[0] = 1'b0;
    #1;
    chk("led0_key_lo", led[0], 1'b0);
    #127;
    key[0] = 1'b1;
    #1;
    chk("led0_key_hi", led[0], 1'b1);
  end

  initial begin
    logic [23:0] exp_rgb;
    int          tgt;

    //        x    y   hs  vs  blk  grid        bars        led2
    tbl[0]  = '{0,   0,   1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 0};
    tbl[1]  = '{5,   0,   1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 0};
    tbl[2]  = '{159, 0,   1, 1, 1, 24'hFFFFFF, 24'h000000, 0};
    tbl[3]  = '{160, 0,   1, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[4]  = '{199, 0,   1, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[5]  = '{200, 0,   0, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[6]  = '{247, 0,   0, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[7]  = '{248, 0,   1, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[8]  = '{287, 0,   1, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[9]  = '{5,   5,   1, 1, 1, 24'h000000, 24'hFFFFFF, 0};
    tbl[10] = '{15,  5,   1, 1, 1, 24'h000000, 24'hFFFFFF, 0};
    tbl[11] = '{16,  5,   1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 0};
    tbl[12] = '{30,  10,  1, 1, 1, 24'h000000, 24'hFFFF00, 0};
    tbl[13] = '{50,  10,  1, 1, 1, 24'h000000, 24'h00FFFF, 0};
    tbl[14] = '{150, 10,  1, 1, 1, 24'h000000, 24'h000000, 0};
    tbl[15] = '{48,  20,  1, 1, 1, 24'hFFFFFF, 24'h00FFFF, 0};
    tbl[16] = '{5,   32,  1, 1, 1, 24'hFFFFFF, 24'hFFFFFF, 0};
    tbl[17] = '{159, 89,  1, 1, 1, 24'h000000, 24'h000000, 0};
    tbl[18] = '{0,   90,  1, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[19] = '{0,   102, 1, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[20] = '{0,   103, 1, 0, 0, 24'h000000, 24'h000000, 0};
    tbl[21] = '{210, 105, 0, 0, 0, 24'h000000, 24'h000000, 0};
    tbl[22] = '{0,   106, 1, 1, 0, 24'h000000, 24'h000000, 0};
    tbl[23] = '{287, 134, 1, 1, 0, 24'h000000, 24'h000000, 1};

    rst = 1'b1;
    sw  = 4'h0;
    repeat (3) step();
    chk_reset_state("rst");
    repeat (15) step();
    chk_reset_state("rst_late");

    // Heartbeat, switch mirror and pixel clock phase
    rst    = 1'b0;
    edge_n = 0;
    step();
    chk("vclk_e1", vif.VGA_CLK, 1'b0);
    chk("led3_e1", led[3], 1'b0);
    step();
    chk("vclk_e2", vif.VGA_CLK, 1'b1);
    step_to(3);
    sw = 4'hA;
    chk("sw_before", led[7:4], 4'h0);
    step();
    chk("sw_after", led[7:4], 4'hA);
    step_to(7);
    chk("hb_e7", led[1], 1'b0);
    step();
    chk("hb_e8", led[1], 1'b1);
    step_to(15);
    chk("hb_e15", led[1], 1'b1);
    step();
    chk("hb_e16", led[1], 1'b0);
    step_to(26);
    chk("hb_e26", led[1], 1'b1);

    rst = 1'b1;
    step();
    chk_reset_state("rst_hb");

    // One full frame: pixel n's outputs appear after edge 2n+2
    rst    = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 24; i++) begin
      tgt = 2 * (tbl[i].y * HT + tbl[i].x) + 2;
      if (i == 23) begin
        step_to(tgt - 1);
        chk("led2_pre_eof", led[2], 1'b0);
      end
      step_to(tgt);
`ifdef COLOR_BARS_EN
      exp_rgb = tbl[i].bars;
`else
      exp_rgb = tbl[i].grid;
`endif
      chk($sformatf("hs[%0d]", i),    vif.VGA_HS, tbl[i].hs);
      chk($sformatf("vs[%0d]", i),    vif.VGA_VS, tbl[i].vs);
      chk($sformatf("blank[%0d]", i), vif.VGA_BLANK, tbl[i].blank);
      chk($sformatf("rgb[%0d]", i),   rgb, exp_rgb);
      chk($sformatf("led2[%0d]", i),  led[2], tbl[i].led2);
    end

    // Reset mid-line at x=100 of the next frame
    step_to(77760 + 2 * 100 + 2);
    chk("mid_blank", vif.VGA_BLANK, 1'b1);
`ifdef COLOR_BARS_EN
    chk("mid_rgb", rgb, 24'hFF0000);
`else
    chk("mid_rgb", rgb, 24'hFFFFFF);
`endif
    rst = 1'b1;
    step();
    chk_reset_state("rst_mid");
    rst    = 1'b0;
    edge_n = 0;
    step_to(2);
    chk("restart_blank", vif.VGA_BLANK, 1'b1);
    chk("restart_rgb", rgb, 24'hFFFFFF);
    chk("restart_hs", vif.VGA_HS, 1'b1);
    step_to(2 * 199 + 2);
    chk("restart_hs199", vif.VGA_HS, 1'b1);
    step_to(2 * 200 + 2);
    chk("restart_hs200", vif.VGA_HS, 1'b0);
    chk("restart_blank200", vif.VGA_BLANK, 1'b0);
    chk("led0_end", led[0], key[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
